// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit (MUL/MULHU/DIVU/REMU) for the execute stage.
// One shift-add or restoring-divide step per cycle; fixed latency for every op.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             Zero_Flag,
  output logic             Sign_Flag
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH-1:0]     r_b;
  logic [1:0]           r_op;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_result;
  logic [WIDTH-1:0]     w_hi;
  logic [WIDTH-1:0]     w_lo;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_part;
  logic [WIDTH-1:0]     w_diff;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_res;
  logic                 w_accept;

  assign w_hi     = r_acc[2*WIDTH-1:WIDTH];
  assign w_lo     = r_acc[WIDTH-1:0];
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_BUSY;
        else       w_state_nxt = S_IDLE;
      end
      S_BUSY: begin
        if (r_cnt == LAST) w_state_nxt = S_DONE;
        else               w_state_nxt = S_BUSY;
      end
      S_DONE: begin
        if (start) w_state_nxt = S_BUSY;
        else       w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state register
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_BUSY:  busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // One iteration: acc holds {product_hi, multiplier} or {remainder, dividend/quotient}.
  // With a zero divisor every step subtracts nothing, giving quotient all-ones and remainder A.
  always_comb begin
    w_sum  = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    w_part = {w_hi, w_lo[WIDTH-1]};
    w_ge   = (w_part >= {1'b0, r_b});
    w_diff = w_part[WIDTH-1:0] - r_b;
    if (r_op[1]) begin
      if (w_ge) w_acc_nxt = {w_diff, w_lo[WIDTH-2:0], 1'b1};
      else      w_acc_nxt = {w_part[WIDTH-1:0], w_lo[WIDTH-2:0], 1'b0};
    end else begin
      w_acc_nxt = {w_sum, w_lo[WIDTH-1:1]};
    end
    if (r_op[0]) w_res = w_acc_nxt[2*WIDTH-1:WIDTH];
    else         w_res = w_acc_nxt[WIDTH-1:0];
  end

  // Operand latch, iteration datapath and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= {(2*WIDTH){1'b0}};
      r_b      <= {WIDTH{1'b0}};
      r_op     <= 2'b00;
      r_cnt    <= {CNT_W{1'b0}};
      r_result <= {WIDTH{1'b0}};
    end else if (w_accept) begin
      r_acc <= {{WIDTH{1'b0}}, A};
      r_b   <= B;
      r_op  <= op;
      r_cnt <= {CNT_W{1'b0}};
    end else if (r_state == S_BUSY) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
      if (r_cnt == LAST) r_result <= w_res;
      else               r_result <= r_result;
    end else begin
      r_acc    <= r_acc;
      r_result <= r_result;
    end
  end

  assign result    = r_result;
  assign Zero_Flag = (r_result == {WIDTH{1'b0}});
  assign Sign_Flag = r_result[WIDTH-1];

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed table, multi-cycle corner sequences
// and randomized operations checked against a plain-arithmetic reference model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero_flag;
  logic        sign_flag;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  mul_div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .A         (a_i),
    .B         (b_i),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .Zero_Flag (zero_flag),
    .Sign_Flag (sign_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    logic [63:0] p;
    p = {32'd0, x} * {32'd0, y};
    case (o)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      default: return (y == 32'd0) ? x : x % y;
    endcase
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op    = o;
    a_i   = x;
    b_i   = y;
    start = 1'b1;
  endtask

  // Called right after issue(); checks latency, busy length, result and flags.
  task automatic wait_done(input string name, input logic [31:0] exp, input bit disturb);
    int lat;
    int bc;
    bit got;
    lat = 0;
    bc  = 0;
    got = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        lat = k;
        break;
      end
      if (busy) bc++;
      if (disturb) begin
        start = 1'($urandom_range(0, 1));
        op    = 2'($urandom);
        a_i   = $urandom;
        b_i   = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({name, "_done_seen"}, 32'(got), 32'd1);
    chk({name, "_latency"}, 32'(lat), 32'd33);
    chk({name, "_busy_cycles"}, 32'(bc), 32'd32);
    chk({name, "_result"}, result, exp);
    chk({name, "_zero"}, 32'(zero_flag), 32'(exp == 32'd0));
    chk({name, "_sign"}, 32'(sign_flag), 32'(exp[31]));
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  ro;
    int          late_done;

    vecs[0] = '{2'd0, 32'd6,          32'd7,          32'd42};
    vecs[1] = '{2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
    vecs[2] = '{2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001};
    vecs[3] = '{2'd2, 32'd100,        32'd7,          32'd14};
    vecs[4] = '{2'd3, 32'd100,        32'd7,          32'd2};
    vecs[5] = '{2'd2, 32'h8000_0000,  32'd1,          32'h8000_0000};
    vecs[6] = '{2'd2, 32'd5,          32'd0,          32'hFFFF_FFFF};
    vecs[7] = '{2'd3, 32'd5,          32'd0,          32'd5};
    vecs[8] = '{2'd0, 32'd0,          32'd12345,      32'd0};

    rst = 1'b1; start = 1'b0; op = 2'd0; a_i = 32'd0; b_i = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_zero", 32'(zero_flag), 32'd1);
    chk("reset_sign", 32'(sign_flag), 32'd0);

    // Directed table
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done($sformatf("vec%0d", i), vecs[i].exp, 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
      chk($sformatf("vec%0d_held", i), result, vecs[i].exp);
    end

    // Inputs toggled while busy must not affect the in-flight operation
    issue(2'd0, 32'd6, 32'd7);
    wait_done("disturb_mul", 32'd42, 1'b1);
    issue(2'd2, 32'd1000, 32'd10);
    wait_done("disturb_divu", 32'd100, 1'b1);

    // Back-to-back: start during the done cycle
    issue(2'd3, 32'd100, 32'd7);
    wait_done("b2b_first", 32'd2, 1'b0);
    issue(2'd1, 32'h0001_0000, 32'h0001_0000);
    wait_done("b2b_second", 32'd1, 1'b0);

    // Reset during the 10th busy cycle
    issue(2'd0, 32'd3, 32'd5);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_zero", 32'(zero_flag), 32'd1);
    late_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) late_done++;
    end
    chk("midrst_no_done", 32'(late_done), 32'd0);
    issue(2'd0, 32'd3, 32'd5);
    wait_done("after_rst", 32'd15, 1'b0);

    // rst and start together: rst wins
    rst = 1'b1;
    issue(2'd0, 32'd9, 32'd9);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", 32'(busy), 32'd0);
    chk("rst_start_result", result, 32'd0);
    @(negedge clk);
    chk("rst_start_busy2", 32'(busy), 32'd0);
    chk("rst_start_done2", 32'(done), 32'd0);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 7));
        1:       rb = ra;
        default: rb = $urandom;
      endcase
      issue(ro, ra, rb);
      wait_done($sformatf("rand%0d_op%0d", i, ro), ref_model(ro, ra, rb), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
